regfile_sequencer: RTL
======================

# regfile_sequencer

Multi-cycle instruction sequencer that drives the 4-entry × 4-bit register file (two read ports, one write port).
- Accepts one instruction at a time over a valid/ready handshake.
- Reads the source registers, computes a 4-bit ALU result and writes it back through the register-file write port.
- Sits between the instruction source (test harness or future fetch unit) and the register file; it is the only master of the register file's address and write-enable inputs.

## Interface
Parameters: none; data width fixed at 4, register address width fixed at 2.

All vectors are declared MSB-first, index 0 = MSB, matching the register file ports.

Ports:
- CLK  in  1  single clock; all state changes on rising edge
- RST  in  1  reset, synchronous, active-high
- IN_VALID  in  1  instruction present on IN_OP/IN_RD/IN_RS/IN_RT/IN_IMM
- IN_READY  out  1  sequencer can accept an instruction this cycle
- IN_OP  in  3  opcode
- IN_RD  in  2  destination register
- IN_RS  in  2  source register A
- IN_RT  in  2  source register B
- IN_IMM  in  4  immediate for LDI
- RF_RS  out  2  register file read address A
- RF_RT  out  2  register file read address B
- RF_CRS  in  4  register file read data A (combinational from RF_RS)
- RF_CRT  in  4  register file read data B (combinational from RF_RT)
- RF_RW  out  2  register file write address
- RF_DW  out  4  register file write data
- RF_WE  out  1  register file write enable
- DONE  out  1  one-cycle pulse: instruction retires this cycle
- FLAG_Z  out  1  last result was zero
- FLAG_C  out  1  carry (ADD) / borrow (SUB) of last result

## Operation
Opcodes:
- 000 NOP: no write
- 001 LDI: RD ← IMM
- 010 ADD: RD ← RS+RT mod 16
- 011 SUB: RD ← RS−RT mod 16
- 100 AND
- 101 OR
- 110 XOR
- 111 MOV: RD ← RS

FSM states:
- IDLE
  - IN_READY=1.
  - On IN_VALID=1 at a rising edge, latch op/rd/rs/rt/imm into internal registers and go to READ.
  - Otherwise stay in IDLE.
- READ
  - RF_RS/RF_RT driven from the latched rs/rt.
  - At the end of the cycle, capture RF_CRS/RF_CRT into operand registers A/B.
  - Go to EXEC.
- EXEC
  - Compute a 5-bit result from A/B/imm and latch it.
  - Go to WB.
- WB
  - RF_RW=latched rd, RF_DW=result[3:0].
  - RF_WE=1 unless op=NOP.
  - DONE=1.
  - Flags update at the end of the cycle.
  - Go to IDLE.

Datapath rules:
- RF_RS/RF_RT/RF_RW hold their last driven value outside READ/WB. They are don't-care when RF_WE=0; the bench checks them only in READ/WB.
- Flag rules for non-NOP ops:
  - FLAG_Z = (result[3:0]==0).
  - FLAG_C = carry-out for ADD; for SUB, 1 iff A<B (unsigned).
  - FLAG_C = 0 for LDI/AND/OR/XOR/MOV.
- NOP leaves both flags unchanged.
- IN_* inputs are ignored outside IDLE. IN_VALID held high in other states has no effect.
- RD equal to RS or RT is legal: operands are captured in READ, before the write in WB.
- Back-to-back dependent instructions need no forwarding. The write lands at the WB→IDLE edge, and the next READ is at least two cycles later.

## Timing
- Reset (RST=1 at a rising edge):
  - state←IDLE
  - FLAG_Z=0, FLAG_C=0
  - RF_RS/RF_RT/RF_RW/RF_DW=0
  - latched instruction cleared
- While RST=1:
  - IN_READY=0, RF_WE=0, DONE=0.
  - RF_WE and DONE are gated combinationally by RST, so a reset asserted during WB suppresses that write.
- Reset mid-instruction aborts it: no write, no DONE, flags cleared.
- First cycle after RST deasserts: IN_READY=1.
- Latency:
  - Accept edge T0, READ is cycle T0+1, EXEC T0+2, WB T0+3.
  - Register file updated at the rising edge ending WB.
  - IN_READY returns to 1 in cycle T0+4.
- Throughput: one instruction per 4 cycles with IN_VALID held high.
- RF_WE and DONE are exactly one cycle wide per instruction. DONE pulses for NOP as well.

## Test plan
- Reset:
  - Hold RST 2 cycles during a WB of ADD R1.
  - R1 is unchanged.
  - After release: IN_READY=1, FLAG_Z=0, FLAG_C=0, RF_WE=0.
- LDI then read back:
  - Issue LDI R2,0xA, then MOV R3,R2.
  - RF_WE high exactly in cycles T0+3 and T0+7 (second instruction accepted at T0+4).
  - R3=0xA, FLAG_Z=0.
- ADD overflow:
  - R0=0x9, R1=0x8; ADD R2,R0,R1.
  - R2=0x1, FLAG_C=1, FLAG_Z=0.
  - ADD 0x8+0x8 → R=0x0, FLAG_C=1, FLAG_Z=1.
- SUB borrow and in-place:
  - R1=0x3, R2=0x5; SUB R1,R1,R2.
  - R1=0xE, FLAG_C=1.
  - SUB 0x5−0x5 → 0x0, FLAG_Z=1, FLAG_C=0.
- Handshake and NOP:
  - Hold IN_VALID=1 continuously with four instructions.
  - Exactly one accept every 4 cycles; IN_* changes outside IDLE are ignored.
  - NOP pulses DONE with RF_WE=0 and flags unchanged.
- Logic ops:
  - R0=0xC, R1=0xA.
  - AND→0x8, OR→0xE, XOR→0x6, each with FLAG_C=0.

Source files
------------

// File: rtl/regfile_sequencer.sv
// regfile_sequencer: four-state (IDLE/READ/EXEC/WB) instruction sequencer that
// reads two sources from a 4x4 register file, runs a 4-bit ALU op and writes back.
`default_nettype none

module regfile_sequencer (
   input  logic       CLK,
   input  logic       RST,
   input  logic       IN_VALID,
   output logic       IN_READY,
   input  logic [0:2] IN_OP,
   input  logic [0:1] IN_RD,
   input  logic [0:1] IN_RS,
   input  logic [0:1] IN_RT,
   input  logic [0:3] IN_IMM,
   output logic [0:1] RF_RS,
   output logic [0:1] RF_RT,
   input  logic [0:3] RF_CRS,
   input  logic [0:3] RF_CRT,
   output logic [0:1] RF_RW,
   output logic [0:3] RF_DW,
   output logic       RF_WE,
   output logic       DONE,
   output logic       FLAG_Z,
   output logic       FLAG_C
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      READ = 2'd1,
      EXEC = 2'd2,
      WB   = 2'd3
   } state_t;

   localparam logic [2:0] OP_NOP = 3'b000;
   localparam logic [2:0] OP_LDI = 3'b001;
   localparam logic [2:0] OP_ADD = 3'b010;
   localparam logic [2:0] OP_SUB = 3'b011;
   localparam logic [2:0] OP_AND = 3'b100;
   localparam logic [2:0] OP_OR  = 3'b101;
   localparam logic [2:0] OP_XOR = 3'b110;
   localparam logic [2:0] OP_MOV = 3'b111;

   state_t     state, state_nxt;
   logic [2:0] op;
   logic [1:0] rd;
   logic [3:0] imm;
   logic [1:0] rs_addr, rt_addr, rw_addr;
   logic [3:0] opa, opb, dw;
   logic [4:0] res, res_nxt;
   logic       flag_z, flag_c;

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= state_nxt;
   end

   // RST gates the handshake and write strobes combinationally so a reset
   // arriving during WB suppresses that cycle's write.
   always_comb begin
      state_nxt = state;
      IN_READY  = 1'b0;
      RF_WE     = 1'b0;
      DONE      = 1'b0;
      case (state)
         IDLE: begin
            IN_READY = !RST;
            if (IN_VALID) state_nxt = READ;
         end
         READ: state_nxt = EXEC;
         EXEC: state_nxt = WB;
         WB: begin
            RF_WE     = !RST && (op != OP_NOP);
            DONE      = !RST;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Bit 4 carries ADD carry-out; for SUB it is the borrow, i.e. opa < opb.
   always_comb begin
      res_nxt = 5'd0;
      case (op)
         OP_LDI:  res_nxt = {1'b0, imm};
         OP_ADD:  res_nxt = {1'b0, opa} + {1'b0, opb};
         OP_SUB:  res_nxt = {1'b0, opa} - {1'b0, opb};
         OP_AND:  res_nxt = {1'b0, opa & opb};
         OP_OR:   res_nxt = {1'b0, opa | opb};
         OP_XOR:  res_nxt = {1'b0, opa ^ opb};
         OP_MOV:  res_nxt = {1'b0, opa};
         default: res_nxt = 5'd0;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         op      <= OP_NOP;
         rd      <= 2'd0;
         imm     <= 4'd0;
         rs_addr <= 2'd0;
         rt_addr <= 2'd0;
         rw_addr <= 2'd0;
         opa     <= 4'd0;
         opb     <= 4'd0;
         dw      <= 4'd0;
         res     <= 5'd0;
         flag_z  <= 1'b0;
         flag_c  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (IN_VALID) begin
                  op      <= IN_OP;
                  rd      <= IN_RD;
                  rs_addr <= IN_RS;
                  rt_addr <= IN_RT;
                  imm     <= IN_IMM;
               end
            end
            READ: begin
               opa <= RF_CRS;
               opb <= RF_CRT;
            end
            EXEC: begin
               res     <= res_nxt;
               rw_addr <= rd;
               dw      <= res_nxt[3:0];
            end
            WB: begin
               if (op != OP_NOP) begin
                  flag_z <= (res[3:0] == 4'd0);
                  flag_c <= res[4];
               end
            end
            default: ;
         endcase
      end
   end

   assign RF_RS  = rs_addr;
   assign RF_RT  = rt_addr;
   assign RF_RW  = rw_addr;
   assign RF_DW  = dw;
   assign FLAG_Z = flag_z;
   assign FLAG_C = flag_c;

endmodule

`default_nettype wire
